// File: rtl/perf_pkg.sv
// Shared constants and types for the performance counter bank.
// Event indices name the channel each core event is wired to.
package perf_pkg;

    localparam int EV_STALL      = 0;
    localparam int EV_BUBBLE     = 1;
    localparam int EV_L1I_HIT    = 2;
    localparam int EV_L1I_MISS   = 3;
    localparam int EV_L1D_HIT    = 4;
    localparam int EV_L1D_MISS   = 5;
    localparam int EV_L2_HIT     = 6;
    localparam int EV_L2_MISS    = 7;
    localparam int EV_BR         = 8;
    localparam int EV_BR_CORR    = 9;
    localparam int EV_BTB_MISS   = 10;
    localparam int EV_BP_MISP_NT = 11;
    localparam int EV_BP_MISP_T  = 12;
    localparam int NUM_EV        = 13;

    typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;

endpackage

// File: rtl/perf_counter_bank_if.sv
// Read port of the performance counter bank: request/address in, registered response out.
interface perf_counter_bank_if #(
    parameter int AW    = 4,
    parameter int CNT_W = 32
);
    logic             rd_req;
    logic [AW-1:0]    rd_addr;
    logic             rd_valid;
    logic [CNT_W-1:0] rd_data;
    logic             rd_ovf;
    logic             rd_err;

    modport master (output rd_req, rd_addr, input rd_valid, rd_data, rd_ovf, rd_err);
    modport slave  (input rd_req, rd_addr, output rd_valid, rd_data, rd_ovf, rd_err);
endinterface

// File: rtl/perf_counter_ch.sv
// One live event counter with sticky overflow and per-channel wrap/saturate behaviour.
module perf_counter_ch #(
    parameter int CNT_W = 32,
    parameter int INC_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             cnt_en,
    input  logic             sat_mode,
    input  logic [INC_W-1:0] inc,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf
);

    logic [CNT_W:0] sum;

    // Carry-out of the widened sum is the overflow condition in both modes
    assign sum = {1'b0, cnt} + {{(CNT_W + 1 - INC_W){1'b0}}, inc};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (cnt_en) begin
            if (sum[CNT_W]) begin
                ovf <= 1'b1;
                cnt <= sat_mode ? '1 : sum[CNT_W-1:0];
            end else begin
                cnt <= sum[CNT_W-1:0];
            end
        end
    end

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of event counters with shadow snapshots, optional periodic auto-snapshot
// and a one-cycle-latency registered read port.
module perf_counter_bank
    import perf_pkg::*;
#(
    parameter int NUM_CH        = 16,
    parameter int CNT_W         = 32,
    parameter int INC_W         = 2,
    parameter int SNAP_INTERVAL = 0,
    parameter int AW            = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH*INC_W-1:0] evt_inc,
    input  logic                    cnt_en,
    input  logic                    clr,
    input  logic [NUM_CH-1:0]       sat_mode,
    input  logic                    snap,
    perf_counter_bank_if.slave      rd,
    output logic [NUM_CH-1:0]       ovf_flags,
    output logic                    snap_done
);

    logic [NUM_CH-1:0][CNT_W-1:0] live_cnt;
    logic [NUM_CH-1:0][CNT_W-1:0] shadow;
    logic [NUM_CH-1:0]            shadow_ovf;
    logic                         tmr_fire;
    logic                         snap_any;
    logic [CNT_W-1:0]             sel_cnt;
    logic                         sel_ovf;
    logic                         sel_err;
    rd_state_t                    rd_state;

    for (genvar g = 0; g < NUM_CH; g++) begin : gen_ch
        perf_counter_ch #(.CNT_W(CNT_W), .INC_W(INC_W)) u_ch (
            .clk      (clk),
            .rst      (rst),
            .clr      (clr),
            .cnt_en   (cnt_en),
            .sat_mode (sat_mode[g]),
            .inc      (evt_inc[g*INC_W +: INC_W]),
            .cnt      (live_cnt[g]),
            .ovf      (ovf_flags[g])
        );
    end

    if (SNAP_INTERVAL > 0) begin : g_tmr
        localparam int TW = (SNAP_INTERVAL > 1) ? $clog2(SNAP_INTERVAL) : 1;
        logic [TW-1:0] tmr;

        // Timer advances on enabled cycles only; clr wins over a pending fire
        assign tmr_fire = cnt_en && !clr && (tmr == TW'(SNAP_INTERVAL - 1));

        always_ff @(posedge clk or negedge rst) begin
            if (!rst)        tmr <= '0;
            else if (clr)    tmr <= '0;
            else if (cnt_en) tmr <= tmr_fire ? '0 : tmr + 1'b1;
        end
    end else begin : g_no_tmr
        assign tmr_fire = 1'b0;
    end

    assign snap_any = snap | tmr_fire;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow     <= '0;
            shadow_ovf <= '0;
            snap_done  <= 1'b0;
        end else begin
            snap_done <= snap_any;
            if (snap_any) begin
                shadow     <= live_cnt;
                shadow_ovf <= ovf_flags;
            end
        end
    end

    // A snapshot landing on the request edge is forwarded so the read sees it
    always_comb begin
        sel_cnt = '0;
        sel_ovf = 1'b0;
        sel_err = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd.rd_addr == AW'(i)) begin
                sel_err = 1'b0;
                sel_cnt = snap_any ? live_cnt[i]  : shadow[i];
                sel_ovf = snap_any ? ovf_flags[i] : shadow_ovf[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_state   <= RD_IDLE;
            rd.rd_data <= '0;
            rd.rd_ovf  <= 1'b0;
            rd.rd_err  <= 1'b0;
        end else begin
            case (rd_state)
                RD_IDLE: if (rd.rd_req)  rd_state <= RD_RESP;
                RD_RESP: if (!rd.rd_req) rd_state <= RD_IDLE;
            endcase
            if (rd.rd_req) begin
                rd.rd_data <= sel_cnt;
                rd.rd_ovf  <= sel_ovf;
                rd.rd_err  <= sel_err;
            end
        end
    end

    assign rd.rd_valid = (rd_state == RD_RESP);

endmodule

// File: tb/tb_perf_counter_bank.sv
// Randomized bench for perf_counter_bank against an arithmetic reference model.
module tb_perf_counter_bank;

    localparam int NCH  = 12;
    localparam int CW   = 4;
    localparam int IW   = 2;
    localparam int SI   = 8;
    localparam int AW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NCH*IW-1:0]    evt_inc;
    logic                 cnt_en, clr, snap;
    logic [NCH-1:0]       sat_mode;
    logic [NCH-1:0]       ovf_flags;
    logic                 snap_done;

    perf_counter_bank_if #(.AW(AW), .CNT_W(CW)) rd_if ();

    perf_counter_bank #(.NUM_CH(NCH), .CNT_W(CW), .INC_W(IW), .SNAP_INTERVAL(SI)) dut (
        .clk(clk), .rst(rst), .evt_inc(evt_inc), .cnt_en(cnt_en), .clr(clr),
        .sat_mode(sat_mode), .snap(snap), .rd(rd_if), .ovf_flags(ovf_flags),
        .snap_done(snap_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: plain integers per channel
    int m_live[NCH], m_ovf[NCH], m_sh[NCH], m_shovf[NCH];
    int m_enabled_since_clr;
    int m_sd, m_rv, m_rd, m_ro, m_re;

    function automatic void model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_live[i] = 0; m_ovf[i] = 0; m_sh[i] = 0; m_shovf[i] = 0;
        end
        m_enabled_since_clr = 0;
        m_sd = 0; m_rv = 0; m_rd = 0; m_ro = 0; m_re = 0;
    endfunction

    function automatic logic [NCH-1:0] model_ovf_vec();
        logic [NCH-1:0] v;
        for (int i = 0; i < NCH; i++) v[i] = (m_ovf[i] != 0);
        return v;
    endfunction

    task automatic set_inc(input int ch, input int v);
        evt_inc[ch*IW +: IW] = IW'(v);
    endtask

    task automatic idle();
        cnt_en = 0; clr = 0; snap = 0; evt_inc = '0; rd_if.rd_req = 0; rd_if.rd_addr = '0;
    endtask

    // Apply one clock edge to the model, then advance the DUT and settle
    task automatic tick();
        int s, a;
        bit fire;
        fire = cnt_en && !clr && ((m_enabled_since_clr + 1) % SI == 0);
        if (snap || fire)
            for (int i = 0; i < NCH; i++) begin
                m_sh[i] = m_live[i]; m_shovf[i] = m_ovf[i];
            end
        for (int i = 0; i < NCH; i++) begin
            if (clr) begin
                m_live[i] = 0; m_ovf[i] = 0;
            end else if (cnt_en) begin
                s = m_live[i] + int'(evt_inc[i*IW +: IW]);
                if (s > CMAX) begin
                    m_ovf[i] = 1;
                    m_live[i] = sat_mode[i] ? CMAX : s % (CMAX + 1);
                end else m_live[i] = s;
            end
        end
        if (clr) m_enabled_since_clr = 0;
        else if (cnt_en) m_enabled_since_clr++;
        m_sd = (snap || fire) ? 1 : 0;
        if (rd_if.rd_req) begin
            a = int'(rd_if.rd_addr);
            m_rv = 1;
            if (a >= NCH) begin m_rd = 0; m_ro = 0; m_re = 1; end
            else begin m_rd = m_sh[a]; m_ro = m_shovf[a]; m_re = 0; end
        end else m_rv = 0;
        @(posedge clk); #1;
    endtask

    task automatic do_clr();
        idle(); clr = 1; tick(); clr = 0;
    endtask

    task automatic test_reset();
        idle(); sat_mode = '0; rst = 0; model_reset();
        #12;
        n_cmp++; if (rd_if.rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid got %b want 0", rd_if.rd_valid); end
        n_cmp++; if (rd_if.rd_data !== '0) begin n_err++; $display("FAIL reset_rd_data got %0d want 0", rd_if.rd_data); end
        n_cmp++; if ({rd_if.rd_ovf, rd_if.rd_err} !== 2'b00) begin n_err++; $display("FAIL reset_rd_ovf_err got %b want 00", {rd_if.rd_ovf, rd_if.rd_err}); end
        n_cmp++; if (ovf_flags !== '0 || snap_done !== 1'b0) begin n_err++; $display("FAIL reset_flags got ovf=%h sd=%b want 0/0", ovf_flags, snap_done); end
        rst = 1;
        tick();
    endtask

    task automatic test_count();
        do_clr();
        sat_mode = NCH'($urandom);
        cnt_en = 1;
        for (int k = 0; k < 10; k++) begin
            for (int i = 1; i < NCH; i++) set_inc(i, int'($urandom_range(0, 3)));
            set_inc(0, 1);
            tick();
        end
        idle(); snap = 1; tick(); snap = 0;
        n_cmp++; if (snap_done !== 1'b1 || rd_if.rd_valid !== 1'b0) begin n_err++; $display("FAIL count_pre_read got sd=%b vld=%b want 1/0", snap_done, rd_if.rd_valid); end
        rd_if.rd_req = 1; rd_if.rd_addr = 0; tick(); rd_if.rd_req = 0;
        n_cmp++; if (rd_if.rd_valid !== 1'b1 || rd_if.rd_data !== 4'd10 || rd_if.rd_err !== 1'b0) begin n_err++; $display("FAIL count_read got vld=%b data=%0d err=%b want 1/10/0", rd_if.rd_valid, rd_if.rd_data, rd_if.rd_err); end
        tick();
        n_cmp++; if (rd_if.rd_valid !== 1'b0 || rd_if.rd_data !== 4'd10) begin n_err++; $display("FAIL count_hold got vld=%b data=%0d want 0/10", rd_if.rd_valid, rd_if.rd_data); end
        n_cmp++; if (ovf_flags !== model_ovf_vec()) begin n_err++; $display("FAIL count_ovf_flags got %h want %h", ovf_flags, model_ovf_vec()); end
    endtask

    task automatic test_wrap_sat();
        do_clr();
        sat_mode = NCH'($urandom); sat_mode[1] = 0; sat_mode[2] = 1;
        cnt_en = 1;
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < NCH; i++) set_inc(i, int'($urandom_range(0, 3)));
            set_inc(1, 3); set_inc(2, 3);
            tick();
        end
        idle(); snap = 1; tick(); snap = 0;
        n_cmp++; if (ovf_flags[2:1] !== 2'b11) begin n_err++; $display("FAIL ws_ovf_flags got %b want 11", ovf_flags[2:1]); end
        rd_if.rd_req = 1; rd_if.rd_addr = 1; tick();
        n_cmp++; if (rd_if.rd_valid !== 1'b1 || rd_if.rd_data !== 4'd2 || rd_if.rd_ovf !== 1'b1) begin n_err++; $display("FAIL ws_wrap got vld=%b data=%0d ovf=%b want 1/2/1", rd_if.rd_valid, rd_if.rd_data, rd_if.rd_ovf); end
        rd_if.rd_addr = 2; tick(); rd_if.rd_req = 0;
        n_cmp++; if (rd_if.rd_valid !== 1'b1 || rd_if.rd_data !== 4'd15 || rd_if.rd_ovf !== 1'b1) begin n_err++; $display("FAIL ws_sat got vld=%b data=%0d ovf=%b want 1/15/1", rd_if.rd_valid, rd_if.rd_data, rd_if.rd_ovf); end
        n_cmp++; if (ovf_flags !== model_ovf_vec()) begin n_err++; $display("FAIL ws_model_ovf got %h want %h", ovf_flags, model_ovf_vec()); end
    endtask

    task automatic test_collision();
        do_clr();
        sat_mode[3] = 0; cnt_en = 1; set_inc(3, 1);
        for (int k = 0; k < 7; k++) tick();
        clr = 1; snap = 1; tick();
        idle();
        n_cmp++; if (snap_done !== 1'b1 || ovf_flags !== '0) begin n_err++; $display("FAIL coll_flags got sd=%b ovf=%h want 1/0", snap_done, ovf_flags); end
        rd_if.rd_req = 1; rd_if.rd_addr = 3; tick(); rd_if.rd_req = 0;
        n_cmp++; if (rd_if.rd_data !== 4'd7 || rd_if.rd_ovf !== 1'b0) begin n_err++; $display("FAIL coll_shadow got data=%0d ovf=%b want 7/0", rd_if.rd_data, rd_if.rd_ovf); end
        snap = 1; rd_if.rd_req = 1; tick(); idle();
        n_cmp++; if (rd_if.rd_data !== 4'd0 || rd_if.rd_data !== 4'(m_rd)) begin n_err++; $display("FAIL coll_live got %0d want 0", rd_if.rd_data); end
    endtask

    task automatic test_auto_snap();
        int nsnap, prev;
        nsnap = 0; prev = 0;
        do_clr();
        sat_mode[0] = 0;
        rd_if.rd_req = 1; rd_if.rd_addr = 0;
        for (int k = 0; k < 30; k++) begin
            cnt_en = !(k == 10 || k == 11);
            for (int i = 1; i < NCH; i++) set_inc(i, int'($urandom_range(0, 3)));
            set_inc(0, 1);
            tick();
            n_cmp++; if (snap_done !== 1'(m_sd)) begin n_err++; $display("FAIL auto_snap_done cyc %0d got %b want %0d", k, snap_done, m_sd); end
            n_cmp++; if (rd_if.rd_valid !== 1'b1 || rd_if.rd_data !== 4'(m_rd)) begin n_err++; $display("FAIL auto_read cyc %0d got vld=%b data=%0d want 1/%0d", k, rd_if.rd_valid, rd_if.rd_data, m_rd); end
            if (snap_done === 1'b1) begin
                nsnap++;
                if (nsnap == 1) begin
                    n_cmp++; if (rd_if.rd_data !== 4'd7) begin n_err++; $display("FAIL auto_first got %0d want 7", rd_if.rd_data); end
                end else begin
                    n_cmp++; if (int'(rd_if.rd_data) != (prev + 8) % 16) begin n_err++; $display("FAIL auto_step got %0d want %0d", rd_if.rd_data, (prev + 8) % 16); end
                end
                prev = int'(rd_if.rd_data);
            end
        end
        idle();
        n_cmp++; if (nsnap != 3) begin n_err++; $display("FAIL auto_count got %0d want 3", nsnap); end
    endtask

    task automatic test_back_to_back();
        int addrs[4];
        addrs = '{0, 1, 2, NCH};
        idle(); snap = 1; tick(); snap = 0;
        rd_if.rd_req = 1;
        for (int k = 0; k < 4; k++) begin
            rd_if.rd_addr = AW'(addrs[k]);
            tick();
            n_cmp++; if (rd_if.rd_valid !== 1'b1 || rd_if.rd_data !== 4'(m_rd) || rd_if.rd_ovf !== 1'(m_ro) || rd_if.rd_err !== 1'(m_re)) begin
                n_err++; $display("FAIL b2b_%0d got vld=%b data=%0d ovf=%b err=%b want 1/%0d/%0d/%0d", k, rd_if.rd_valid, rd_if.rd_data, rd_if.rd_ovf, rd_if.rd_err, m_rd, m_ro, m_re);
            end
        end
        n_cmp++; if (rd_if.rd_err !== 1'b1 || rd_if.rd_data !== 4'd0 || rd_if.rd_ovf !== 1'b0) begin n_err++; $display("FAIL b2b_oob got data=%0d ovf=%b err=%b want 0/0/1", rd_if.rd_data, rd_if.rd_ovf, rd_if.rd_err); end
        rd_if.rd_req = 0; tick();
        n_cmp++; if (rd_if.rd_valid !== 1'b0 || rd_if.rd_err !== 1'b1) begin n_err++; $display("FAIL b2b_hold got vld=%b err=%b want 0/1", rd_if.rd_valid, rd_if.rd_err); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 60; k++) begin
            cnt_en = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 15) == 0);
            snap = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) sat_mode = NCH'($urandom);
            evt_inc = (NCH*IW)'($urandom);
            rd_if.rd_req = ($urandom_range(0, 2) != 0);
            rd_if.rd_addr = AW'($urandom_range(0, 15));
            tick();
            n_cmp++; if (ovf_flags !== model_ovf_vec() || snap_done !== 1'(m_sd) || rd_if.rd_valid !== 1'(m_rv)) begin
                n_err++; $display("FAIL rand_ctl cyc %0d got ovf=%h sd=%b vld=%b want %h/%0d/%0d", k, ovf_flags, snap_done, rd_if.rd_valid, model_ovf_vec(), m_sd, m_rv);
            end
            if (m_rv != 0) begin
                n_cmp++; if (rd_if.rd_data !== 4'(m_rd) || rd_if.rd_ovf !== 1'(m_ro) || rd_if.rd_err !== 1'(m_re)) begin
                    n_err++; $display("FAIL rand_rd cyc %0d got data=%0d ovf=%b err=%b want %0d/%0d/%0d", k, rd_if.rd_data, rd_if.rd_ovf, rd_if.rd_err, m_rd, m_ro, m_re);
                end
            end
        end
        idle();
    endtask

    task automatic test_async_reset();
        do_clr();
        sat_mode[0] = 0; sat_mode[5] = 0; cnt_en = 1; set_inc(5, 3); set_inc(0, 3);
        for (int k = 0; k < 8; k++) tick();
        idle(); snap = 1; rd_if.rd_req = 1; rd_if.rd_addr = 5; tick(); idle();
        n_cmp++; if (rd_if.rd_valid !== 1'b1 || rd_if.rd_data !== 4'd8 || ovf_flags[5] !== 1'b1) begin n_err++; $display("FAIL ar_pre got vld=%b data=%0d ovf5=%b want 1/8/1", rd_if.rd_valid, rd_if.rd_data, ovf_flags[5]); end
        #2 rst = 0;
        #1;
        n_cmp++; if (rd_if.rd_valid !== 1'b0 || rd_if.rd_data !== '0 || ovf_flags !== '0 || snap_done !== 1'b0) begin
            n_err++; $display("FAIL ar_async got vld=%b data=%0d ovf=%h sd=%b want all 0", rd_if.rd_valid, rd_if.rd_data, ovf_flags, snap_done);
        end
        model_reset();
        #2 rst = 1;
        tick();
        snap = 1; tick(); snap = 0;
        rd_if.rd_req = 1; rd_if.rd_addr = 5; tick(); idle();
        n_cmp++; if (rd_if.rd_valid !== 1'b1 || rd_if.rd_data !== 4'd0 || rd_if.rd_ovf !== 1'b0) begin n_err++; $display("FAIL ar_post got vld=%b data=%0d ovf=%b want 1/0/0", rd_if.rd_valid, rd_if.rd_data, rd_if.rd_ovf); end
    endtask

    initial begin
        test_reset();
        test_count();
        test_wrap_sat();
        test_collision();
        test_auto_snap();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
